kugelblitz_rewrite_ctrl: RTL

- Per-port controller that sequences byte-rewrite rules onto one 512-bit AXI-stream path of the kugelblitz offload.
- Holds a shadow rule table written by software and an active table that drives the datapath. Each rule is a byte offset within the frame plus a replacement byte.
- Tracks frame and beat position by snooping the stream handshake, and emits a per-beat overwrite mask and data for the datapath mux.
- Shadow-to-active swaps happen only on frame boundaries, so a frame is never rewritten by a mix of old and new rules.

---
 rtl/kugelblitz_rewrite_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/kugelblitz_rewrite_ctrl.sv
// kugelblitz_rewrite_ctrl
// Per-port byte-rewrite rule sequencer for one 512-bit AXI-stream path.
// Software writes a shadow rule table. A commit request copies it into the
// active table, but only on a frame boundary. The active table and the
// snooped beat position produce a per-beat overwrite mask and data, which
// the datapath mux uses directly.
//
// Handshake semantics (both interfaces):
//   - A cfg write takes effect on a rising edge where cfg_valid && cfg_ready.
//     cfg_ready is low while a commit is pending, so the shadow table cannot
//     change between the commit request and the swap.
//   - A stream beat is consumed on a rising edge where mon_tvalid && mon_tready.
//     With tvalid high and tready low, nothing advances.
module kugelblitz_rewrite_ctrl #(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int RULE_COUNT   = 4,
    parameter int IDX_WIDTH    = $clog2(RULE_COUNT),
    parameter int OFFSET_WIDTH = 11,
    parameter int BEAT_WIDTH   = OFFSET_WIDTH - $clog2(KEEP_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [IDX_WIDTH-1:0]    cfg_index,
    input  logic [OFFSET_WIDTH-1:0] cfg_offset,
    input  logic [7:0]              cfg_data,
    input  logic                    cfg_enable,
    input  logic                    commit,
    output logic                    commit_pending,
    input  logic                    mon_tvalid,
    input  logic                    mon_tready,
    input  logic                    mon_tlast,
    output logic [KEEP_WIDTH-1:0]   ovr_mask,
    output logic [DATA_WIDTH-1:0]   ovr_data,
    output logic                    frame_active,
    output logic [BEAT_WIDTH:0]     beat_count,
    output logic [31:0]             frame_count
);

    // Low offset bits select the byte within a beat; high bits select the beat.
    localparam int BYTE_SEL_W = $clog2(KEEP_WIDTH);
    localparam logic [BEAT_WIDTH:0] BEAT_MAX = '1;

    typedef struct packed {
        logic                    en;
        logic [OFFSET_WIDTH-1:0] offset;
        logic [7:0]              data;
    } rule_t;

    typedef enum logic {
        IDLE    = 1'b0,
        INFRAME = 1'b1
    } state_t;

    rule_t  shadow_tbl [RULE_COUNT];
    rule_t  active_tbl [RULE_COUNT];

    state_t              state;
    state_t              state_nxt;
    logic [BEAT_WIDTH:0] beat_nxt;
    logic [31:0]         frame_nxt;

    logic hs;
    logic hs_last;
    logic cfg_fire;
    logic swap;
    logic beat_in_range;

    assign hs       = mon_tvalid & mon_tready;
    assign hs_last  = hs & mon_tlast;
    assign cfg_ready = ~commit_pending;
    assign cfg_fire = cfg_valid & cfg_ready;

    // The swap lands either while idle with no frame starting on this edge, or
    // on the edge that consumes the last beat of a frame. The frame is then
    // rewritten entirely by the old table or entirely by the new one.
    assign swap = commit_pending & (hs_last | ((state == IDLE) & ~hs));

    assign frame_active = (state == INFRAME);

    // Frame-position state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat_count  <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            beat_count  <= beat_nxt;
            frame_count <= frame_nxt;
        end
    end

    // Next-state logic: advance beat and frame position on consumed beats.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_count;
        frame_nxt = frame_count;
        case (state)
            IDLE: begin
                if (hs) begin
                    if (mon_tlast) begin
                        frame_nxt = frame_count + 32'd1;
                    end else begin
                        state_nxt = INFRAME;
                        beat_nxt  = (BEAT_WIDTH + 1)'(1);
                    end
                end
            end
            INFRAME: begin
                if (hs) begin
                    if (mon_tlast) begin
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                        frame_nxt = frame_count + 32'd1;
                    end else if (beat_count != BEAT_MAX) begin
                        beat_nxt = beat_count + (BEAT_WIDTH + 1)'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    // Commit request tracking; a commit while already pending is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_pending <= 1'b0;
        end else if (swap) begin
            commit_pending <= 1'b0;
        end else if (commit) begin
            commit_pending <= 1'b1;
        end
    end

    // Shadow table: the only table software can write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RULE_COUNT; i++) begin
                shadow_tbl[i] <= '0;
            end
        end else if (cfg_fire) begin
            shadow_tbl[cfg_index] <= '{en: cfg_enable, offset: cfg_offset, data: cfg_data};
        end
    end

    // Active table: loaded wholesale from the shadow table on a swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RULE_COUNT; i++) begin
                active_tbl[i] <= '0;
            end
        end else if (swap) begin
            for (int i = 0; i < RULE_COUNT; i++) begin
                active_tbl[i] <= shadow_tbl[i];
            end
        end
    end

    // Beats past the addressable offset range never match. This keeps beat
    // 32+n from aliasing onto beat n.
    assign beat_in_range = ~beat_count[BEAT_WIDTH];

    // Rule match, driven only by registered state. Higher indices are applied
    // first, so the lowest matching index ends up owning a shared byte.
    always_comb begin
        ovr_mask = '0;
        ovr_data = '0;
        for (int r = RULE_COUNT - 1; r >= 0; r--) begin
            if (active_tbl[r].en && beat_in_range &&
                (active_tbl[r].offset[OFFSET_WIDTH-1:BYTE_SEL_W] == beat_count[BEAT_WIDTH-1:0])) begin
                ovr_mask[active_tbl[r].offset[BYTE_SEL_W-1:0]] = 1'b1;
                ovr_data[{active_tbl[r].offset[BYTE_SEL_W-1:0], 3'b000} +: 8] = active_tbl[r].data;
            end
        end
    end

endmodule
